imm_sign_extender: RTL and testbench



---
 rtl/imm_sign_extender.sv | 60 ++++++
 tb/tb_imm_sign_extender.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/imm_sign_extender.sv
// RV32I immediate generator: decodes I/S/B/J immediates from instr[31:7]
// and presents the sign-extended value through one register stage.
module imm_sign_extender #(
    parameter int XLEN     = 32,
    parameter int IMM_IN_W = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [IMM_IN_W-1:0] inm,
    input  logic [1:0]          src,
    output logic [XLEN-1:0]     inm_ext,
    output logic                out_valid
);

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    logic [XLEN-1:0] imm_d, imm_q;
    logic            vld_d, vld_q;
    logic            s;
    imm_src_e        sel;

    // inm[k] is instr[k+7], so instr[31] lands on inm[24].
    assign s   = inm[24];
    assign sel = imm_src_e'(src);

    always_comb begin
        imm_d = imm_q;
        vld_d = 1'b0;
        if (in_valid) begin
            vld_d = 1'b1;
            unique case (sel)
                IMM_I:   imm_d = {{20{s}}, inm[24:13]};
                IMM_S:   imm_d = {{20{s}}, inm[24:18], inm[4:0]};
                IMM_B:   imm_d = {{20{s}}, inm[0], inm[23:18], inm[4:1], 1'b0};
                IMM_J:   imm_d = {{12{s}}, inm[12:5], inm[13], inm[23:14], 1'b0};
                default: imm_d = imm_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q <= '0;
            vld_q <= 1'b0;
        end else begin
            imm_q <= imm_d;
            vld_q <= vld_d;
        end
    end

    assign inm_ext   = imm_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_imm_sign_extender.sv
// Directed and random checks of imm_sign_extender against an instruction-level
// reference built from the RV32I immediate layouts.
module tb_imm_sign_extender;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [24:0] inm = '0;
    logic [1:0]  src = '0;
    logic [31:0] inm_ext;
    logic        out_valid;

    int total = 0;
    int fails = 0;

    imm_sign_extender #(.XLEN(32), .IMM_IN_W(25)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inm       (inm),
        .src       (src),
        .inm_ext   (inm_ext),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference written against full-instruction bit positions.
    function automatic logic [31:0] ref_imm(input logic [24:0] f, input logic [1:0] sel);
        logic [31:0] ins;
        ins = {f, 7'b0};
        case (sel)
            2'b00: ref_imm = {{20{ins[31]}}, ins[31:20]};
            2'b01: ref_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            2'b10: ref_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            default: ref_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic v, input logic [24:0] f, input logic [1:0] sel);
        @(negedge clk);
        in_valid = v;
        inm      = f;
        src      = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input string tag, input logic [24:0] f, input logic [1:0] sel,
                       input logic [31:0] exp);
        step(1'b1, f, sel);
        chk({tag, "_imm"}, inm_ext, exp);
        chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_imm;
        logic        exp_vld;
        logic        v;
        logic [24:0] f;
        logic [1:0]  sel;

        // Held in reset with valid inputs: outputs stay clear.
        #2;
        chk("rst0_imm", inm_ext, 32'h0);
        chk("rst0_vld", {31'b0, out_valid}, 32'd0);
        step(1'b1, 25'h1FFFFFF, 2'b00);
        chk("rst_hold_imm", inm_ext, 32'h0);
        chk("rst_hold_vld", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rel_imm", inm_ext, 32'h0);
        chk("rst_rel_vld", {31'b0, out_valid}, 32'd0);

        cap("pos_i", 25'h00FFFF, 2'b00, 32'h00000007);
        cap("pos_s", 25'h00FFFF, 2'b01, 32'h0000001F);
        cap("pos_b", 25'h00FFFF, 2'b10, 32'h0000081E);
        cap("pos_j", 25'h00FFFF, 2'b11, 32'h000FF806);

        cap("sgn_i", 25'h1000000, 2'b00, 32'hFFFFF800);
        cap("sgn_s", 25'h1000000, 2'b01, 32'hFFFFF800);
        cap("sgn_b", 25'h1000000, 2'b10, 32'hFFFFF000);
        cap("sgn_j", 25'h1000000, 2'b11, 32'hFFF00000);

        cap("one_i", 25'h1FFFFFF, 2'b00, 32'hFFFFFFFF);
        cap("one_s", 25'h1FFFFFF, 2'b01, 32'hFFFFFFFF);
        cap("one_b", 25'h1FFFFFF, 2'b10, 32'hFFFFFFFE);
        cap("one_j", 25'h1FFFFFF, 2'b11, 32'hFFFFFFFE);

        // Hold: inputs change while in_valid is low.
        cap("hold_cap", 25'h00FFFF, 2'b00, 32'h00000007);
        step(1'b0, 25'h1FFFFFF, 2'b11);
        chk("hold_imm", inm_ext, 32'h00000007);
        chk("hold_vld", {31'b0, out_valid}, 32'd0);
        step(1'b0, 25'h0AAAAAA, 2'b10);
        chk("hold2_imm", inm_ext, 32'h00000007);

        // Asynchronous reset at mid-cycle clears outputs without an edge.
        cap("pre_rst", 25'h1FFFFFF, 2'b00, 32'hFFFFFFFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_imm", inm_ext, 32'h0);
        chk("async_rst_vld", {31'b0, out_valid}, 32'd0);
        #2;
        rst_n = 1'b1;
        in_valid = 1'b0;
        step(1'b0, 25'h1FFFFFF, 2'b01);
        chk("post_rst_imm", inm_ext, 32'h0);
        cap("post_rst_cap", 25'h1FFFFFF, 2'b01, 32'hFFFFFFFF);

        // Random traffic against the reference model.
        exp_imm = 32'hFFFFFFFF;
        for (int n = 0; n < 1000; n++) begin
            v   = 1'($urandom_range(0, 1));
            f   = 25'($urandom);
            sel = 2'($urandom_range(0, 3));
            step(v, f, sel);
            if (v) exp_imm = ref_imm(f, sel);
            exp_vld = v;
            chk("rnd_imm", inm_ext, exp_imm);
            chk("rnd_vld", {31'b0, out_valid}, {31'b0, exp_vld});
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
